// File: rtl/instr_encoder.sv
// RV32I field packer for the program loader: encodes R/LOAD/ALUI/STORE/BRANCH words,
// stamps each with its byte address and flags immediates that do not fit their format.
module instr_encoder #(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int                 MAX_INSTR = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        fmt,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count,
    output logic              done
);
    localparam int CNT_W = $clog2(MAX_INSTR + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic              out_err_q, out_err_d;
    logic [7:0]        err_count_q, err_count_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

    logic        in_fire, out_fire, last_word;
    logic        i_ok, b_ok;
    logic [31:0] enc_word;
    logic        enc_err;

    // I/S immediates are 12-bit signed; B is 13-bit signed with an implicit zero LSB.
    assign i_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign b_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];

    always_comb begin
        enc_word = 32'b0;
        enc_err  = 1'b0;
        case (fmt)
            3'd0: enc_word = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
            3'd1: begin
                enc_word = {imm[11:0], rs1, funct3, rd, 7'b0000011};
                enc_err  = ~i_ok;
            end
            3'd2: begin
                enc_word = {imm[11:0], rs1, funct3, rd, 7'b0010011};
                enc_err  = ~i_ok;
            end
            3'd3: begin
                enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
                enc_err  = ~i_ok;
            end
            3'd4: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
                enc_err  = ~b_ok;
            end
            default: begin
                enc_word = 32'b0;
                enc_err  = 1'b1;
            end
        endcase
    end

    assign in_ready  = (state_q == S_RUN) && (!out_valid_q || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign last_word = in_last || (word_cnt_q == CNT_W'(MAX_INSTR - 1));

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        out_addr_d  = out_addr_q;
        next_addr_d = next_addr_q;
        out_err_d   = out_err_q;
        err_count_d = err_count_q;
        done_d      = done_q;
        word_cnt_d  = word_cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RUN;
                    word_cnt_d  = '0;
                    next_addr_d = BASE_ADDR;
                    err_count_d = 8'd0;
                    done_d      = 1'b0;
                end
            end
            S_RUN: begin
                // A new word may overwrite the one leaving this cycle, so no bubble.
                if (in_fire) begin
                    out_valid_d = 1'b1;
                    instr_d     = enc_word;
                    out_err_d   = enc_err;
                    out_addr_d  = next_addr_q;
                    next_addr_d = next_addr_q + ADDR_W'(4);
                    word_cnt_d  = word_cnt_q + CNT_W'(1);
                    if (enc_err && (err_count_q != 8'hFF))
                        err_count_d = err_count_q + 8'd1;
                    if (last_word)
                        state_d = S_DRAIN;
                end else if (out_fire) begin
                    out_valid_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            instr_q     <= 32'b0;
            out_addr_q  <= BASE_ADDR;
            next_addr_q <= BASE_ADDR;
            out_err_q   <= 1'b0;
            err_count_q <= 8'd0;
            done_q      <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            out_addr_q  <= out_addr_d;
            next_addr_q <= next_addr_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
            done_q      <= done_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign instr     = instr_q;
    assign out_addr  = out_addr_q;
    assign out_err   = out_err_q;
    assign err_count = err_count_q;
    assign done      = done_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed encodings and session control, then random traffic
// scored against an arithmetic model of the encoding rules and session behaviour.
module tb_instr_encoder;
    localparam logic [31:0] BASE = 32'hFFFF_FFF0;
    localparam int          MAXI = 8;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_ready, in_last;
    logic [2:0]  fmt, funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid, out_ready, out_err, done;
    logic [31:0] instr, out_addr;
    logic [7:0]  err_count;

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(BASE), .MAX_INSTR(MAXI)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .out_addr(out_addr),
        .out_err(out_err), .err_count(err_count), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    // session model: 0 idle, 1 accepting, 2 draining last word, 3 done
    int          m_st, m_cnt, m_ec;
    bit          m_ov, m_err, m_done;
    logic [31:0] m_instr, m_addr, m_next;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_ec = 0; m_ov = 0; m_err = 0; m_done = 0;
        m_instr = 0; m_addr = BASE; m_next = BASE;
    endtask

    function automatic void ref_enc(input int f, input logic [31:0] d, a, b, f3, f7, im,
                                    output logic [31:0] w, output bit e);
        w = 0; e = 0;
        case (f)
            0: w = (f7 << 25) + (b << 20) + (a << 15) + (f3 << 12) + (d << 7) + 32'h33;
            1, 2: begin
                w = ((im & 32'hFFF) << 20) + (a << 15) + (f3 << 12) + (d << 7)
                    + ((f == 1) ? 32'h03 : 32'h13);
                e = ($signed(im) < -2048) || ($signed(im) > 2047);
            end
            3: begin
                w = (((im >> 5) & 32'h7F) << 25) + (b << 20) + (a << 15) + (f3 << 12)
                    + ((im & 32'h1F) << 7) + 32'h23;
                e = ($signed(im) < -2048) || ($signed(im) > 2047);
            end
            4: begin
                w = (((im >> 12) & 32'h1) << 31) + (((im >> 5) & 32'h3F) << 25) + (b << 20)
                    + (a << 15) + (f3 << 12) + (((im >> 1) & 32'hF) << 8)
                    + (((im >> 11) & 32'h1) << 7) + 32'h63;
                e = ($signed(im) < -4096) || ($signed(im) > 4095) || ((im % 2) != 0);
            end
            default: begin w = 0; e = 1; end
        endcase
    endfunction

    // One clock of stimulus: drive, compare DUT against model, then advance the model.
    task automatic step(input bit st, input bit v, input bit last, input bit ordy,
                        input logic [2:0] f, input logic [4:0] d, input logic [4:0] a,
                        input logic [4:0] b, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] im);
        bit rdy, ifire, ofire, e;
        logic [31:0] w;
        @(negedge clk);
        start = st; in_valid = v; in_last = last; out_ready = ordy;
        fmt = f; rd = d; rs1 = a; rs2 = b; funct3 = f3; funct7 = f7; imm = im;
        #1;
        rdy = (m_st == 1) && (!m_ov || ordy);
        chk("in_ready", in_ready, rdy);
        chk("out_valid", out_valid, m_ov);
        chk("err_count", err_count, m_ec);
        chk("done", done, m_done);
        if (m_ov) begin
            chk("instr", instr, m_instr);
            chk("out_addr", out_addr, m_addr);
            chk("out_err", out_err, m_err);
        end
        ifire = v && rdy;
        ofire = m_ov && ordy;
        if (st && (m_st == 0 || m_st == 3)) begin
            m_st = 1; m_cnt = 0; m_next = BASE; m_ec = 0; m_done = 0;
        end else if (m_st == 1) begin
            if (ifire) begin
                ref_enc(int'(f), 32'(d), 32'(a), 32'(b), 32'(f3), 32'(f7), im, w, e);
                m_ov = 1; m_instr = w; m_err = e; m_addr = m_next;
                m_next = m_next + 4; m_cnt++;
                if (e && m_ec < 255) m_ec++;
                if (last || m_cnt == MAXI) m_st = 2;
            end else if (ofire) m_ov = 0;
        end else if (m_st == 2 && ofire) begin
            m_ov = 0; m_st = 3; m_done = 1;
        end
    endtask

    task automatic idle(input bit st, input bit ordy);
        step(st, 0, 0, ordy, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_imm();
        logic [31:0] edges [8];
        edges = '{32'd2047, 32'hFFFF_F800, 32'd2048, 32'hFFFF_F7FF,
                  32'd4094, 32'd4095, 32'hFFFF_F000, 32'hFFFF_EFFE};
        case ($urandom % 4)
            0:       return 32'($urandom_range(0, 16383)) - 32'd8192;
            1:       return edges[$urandom % 8];
            2:       return 32'($urandom_range(0, 63)) - 32'd32;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1; start = 0; in_valid = 0; in_last = 0; out_ready = 0;
        fmt = 0; rd = 0; rs1 = 0; rs2 = 0; funct3 = 0; funct7 = 0; imm = 0;
        model_reset();
        #12;
        chk("rst_instr", instr, 32'h0);
        chk("rst_addr", out_addr, BASE);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_errcnt", err_count, 0);
        @(negedge clk);
        reset = 0;

        // session 1: one of each legal format, then back-to-back R words
        idle(1, 1);
        step(0, 1, 0, 1, 3'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        after_edge();
        chk("addi", instr, 32'h0050_0093);
        chk("addi_addr", out_addr, BASE);
        chk("addi_err", out_err, 0);
        step(0, 1, 0, 1, 3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        after_edge();
        chk("sw", instr, 32'h0020_A423);
        chk("sw_addr", out_addr, BASE + 32'd4);
        step(0, 1, 0, 1, 3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
        after_edge();
        chk("beq", instr, 32'hFE20_8EE3);
        chk("beq_addr", out_addr, BASE + 32'd8);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, (i == 2), 1, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
            after_edge();
            chk("add", instr, 32'h0020_81B3);
            chk("add_addr", out_addr, BASE + 32'(4 * (3 + i)));
            chk("add_ready", in_ready, (i < 2) ? 32'd1 : 32'd0);
        end
        idle(0, 1);
        after_edge();
        chk("done1", done, 1);

        // session 2: range/format errors, backpressure, last word
        idle(1, 1);
        step(0, 1, 0, 1, 3'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        after_edge();
        chk("addi2048", instr, 32'h8000_0093);
        chk("addi2048_err", out_err, 1);
        chk("errcnt1", err_count, 1);
        step(0, 1, 0, 1, 3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        after_edge();
        chk("bodd_err", out_err, 1);
        step(0, 1, 0, 1, 3'd6, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        after_edge();
        chk("illegal", instr, 32'h0);
        chk("illegal_err", out_err, 1);
        chk("errcnt3", err_count, 3);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
            after_edge();
            chk("stall_instr", instr, 32'h0);
            chk("stall_ready", in_ready, 0);
        end
        step(0, 1, 1, 1, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        after_edge();
        chk("last_instr", instr, 32'h0020_81B3);
        idle(0, 1);
        after_edge();
        chk("done2", done, 1);

        // session 3: no in_last, closes on the MAX_INSTR-th word
        idle(1, 1);
        for (int i = 0; i < MAXI; i++) begin
            step(0, 1, 0, 1, 3'd1, 5'(i), 5'(i + 1), 5'd0, 3'd2, 7'd0, 32'(i * 4));
            if (i == MAXI - 1) begin
                after_edge();
                chk("max_ready", in_ready, 0);
            end
        end
        idle(0, 1);
        after_edge();
        chk("done_max", done, 1);

        // reset in the middle of a session with a word pending
        idle(1, 1);
        step(0, 1, 0, 0, 3'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        @(posedge clk);
        #2 reset = 1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_addr", out_addr, BASE);
        chk("mid_rst_instr", instr, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 0;
        idle(0, 1);
        after_edge();
        chk("mid_rst_idle_ready", in_ready, 0);

        // random traffic: stray starts, bursts, backpressure, all formats
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 8) == 0, ($urandom % 10) < 7, ($urandom % 10) == 0,
                 ($urandom % 10) < 7, 3'($urandom % 7), 5'($urandom), 5'($urandom),
                 5'($urandom), 3'($urandom), 7'($urandom), pick_imm());
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
